// File: rtl/score_lives_manager.sv
// Game-state FSM with BCD score, lives and level tracking for the monkey game.
// Define SCORE_HIGH_SCORE_EN to keep a persistent high score; otherwise highScoreBCD is 0.
module score_lives_manager #(
  parameter int INIT_LIVES     = 3,
  parameter int POINTS_PER_HIT = 10,
  parameter int HITS_PER_LEVEL = 5,
  parameter int MAX_LEVEL      = 7,
  parameter int FREEZE_FRAMES  = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startKey,
  input  logic        SingleHitPulse,
  input  logic        deathPulse,
  output logic [15:0] scoreBCD,
  output logic [2:0]  lives,
  output logic [2:0]  level,
  output logic [1:0]  gameState,
  output logic        freeze,
  output logic        gameOver,
  output logic [15:0] highScoreBCD
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_DYING     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  localparam logic [3:0] PTS_UNITS  = 4'(POINTS_PER_HIT % 10);
  localparam logic [3:0] PTS_TENS   = 4'(POINTS_PER_HIT / 10);
  localparam logic [2:0] INIT_L     = 3'(INIT_LIVES);
  localparam logic [2:0] MAX_L      = 3'(MAX_LEVEL);
  localparam logic [3:0] HITS_LAST  = 4'(HITS_PER_LEVEL - 1);
  localparam logic [7:0] FREEZE_LD  = 8'(FREEZE_FRAMES);

  state_t      state_q;
  logic [15:0] score_q;
  logic [2:0]  lives_q;
  logic [2:0]  level_q;
  logic [3:0]  hits_q;
  logic [7:0]  frames_q;
  logic        key_low_q;
  logic        freeze_q;
  logic        game_over_q;
  logic [15:0] score_d;
  logic [15:0] score_sum;
  logic [4:0]  carry;
  logic        final_death;

  // Ripple decimal adder: each digit wraps past 9 and carries into the next.
  assign carry[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd_digit
      localparam logic [3:0] ADDEND = (gi == 0) ? PTS_UNITS : (gi == 1) ? PTS_TENS : 4'd0;
      logic [4:0] raw;
      assign raw = {1'b0, score_q[gi*4 +: 4]} + {1'b0, ADDEND} + {4'd0, carry[gi]};
      assign carry[gi+1] = (raw > 5'd9);
      assign score_sum[gi*4 +: 4] = carry[gi+1] ? 4'(raw - 5'd10) : raw[3:0];
    end
  endgenerate

  assign score_d     = carry[4] ? 16'h9999 : score_sum;
  assign final_death = (state_q == ST_PLAYING) && deathPulse && (lives_q <= 3'd1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      lives_q     <= '0;
      level_q     <= '0;
      hits_q      <= '0;
      frames_q    <= '0;
      key_low_q   <= 1'b0;
      freeze_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (startKey) begin
            score_q <= '0;
            lives_q <= INIT_L;
            level_q <= 3'd1;
            hits_q  <= '0;
            state_q <= ST_PLAYING;
          end
        end
        ST_PLAYING: begin
          if (deathPulse) begin
            lives_q  <= (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
            frames_q <= FREEZE_LD;
            if (final_death) begin
              state_q     <= ST_GAME_OVER;
              game_over_q <= 1'b1;
              key_low_q   <= 1'b0;
            end else begin
              state_q  <= ST_DYING;
              freeze_q <= 1'b1;
            end
          end else if (SingleHitPulse) begin
            score_q <= score_d;
            if (hits_q == HITS_LAST) begin
              hits_q <= '0;
              if (level_q < MAX_L) level_q <= level_q + 3'd1;
            end else begin
              hits_q <= hits_q + 4'd1;
            end
          end
        end
        ST_DYING: begin
          if (frames_q == 8'd0) begin
            state_q  <= ST_PLAYING;
            freeze_q <= 1'b0;
          end else if (startOfFrame) begin
            frames_q <= frames_q - 8'd1;
          end
        end
        ST_GAME_OVER: begin
          // A key still held from play must be released before it can restart.
          if (key_low_q && startKey) begin
            state_q     <= ST_IDLE;
            game_over_q <= 1'b0;
          end else if (!startKey) begin
            key_low_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SCORE_HIGH_SCORE_EN
  logic [15:0] high_q;

  // Valid BCD orders the same as plain binary, so a direct compare is digit-wise.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      high_q <= '0;
    end else if (final_death && (score_q > high_q)) begin
      high_q <= score_q;
    end
  end

  assign highScoreBCD = high_q;
`else
  assign highScoreBCD = 16'h0000;
`endif

  assign scoreBCD  = score_q;
  assign lives     = lives_q;
  assign level     = level_q;
  assign gameState = state_q;
  assign freeze    = freeze_q;
  assign gameOver  = game_over_q;

endmodule

// File: tb/tb_score_lives_manager.sv
// Scoreboard bench: an integer game model predicts every cycle, a monitor compares all outputs.
module tb_score_lives_manager;

  localparam int INIT_LIVES = 3;
  localparam int PPH        = 10;
  localparam int HPL        = 5;
  localparam int MAXL       = 7;
  localparam int FF         = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetN = 1'b0;
  logic sof = 1'b0, key = 1'b0, hit = 1'b0, death = 1'b0;
  logic [15:0] score_o, high_o;
  logic [2:0]  lives_o, level_o;
  logic [1:0]  state_o;
  logic        freeze_o, go_o;

  logic s_key = 1'b0, s_hit = 1'b0, s_zero = 1'b0;
  logic [15:0] s_score, s_high;
  logic [2:0]  s_lives, s_level;
  logic [1:0]  s_state;
  logic        s_freeze, s_go;

  score_lives_manager #(
    .INIT_LIVES(INIT_LIVES), .POINTS_PER_HIT(PPH), .HITS_PER_LEVEL(HPL),
    .MAX_LEVEL(MAXL), .FREEZE_FRAMES(FF)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .startKey(key),
    .SingleHitPulse(hit), .deathPulse(death), .scoreBCD(score_o), .lives(lives_o),
    .level(level_o), .gameState(state_o), .freeze(freeze_o), .gameOver(go_o),
    .highScoreBCD(high_o)
  );

  score_lives_manager #(
    .INIT_LIVES(INIT_LIVES), .POINTS_PER_HIT(5), .HITS_PER_LEVEL(HPL),
    .MAX_LEVEL(MAXL), .FREEZE_FRAMES(FF)
  ) dut_sat (
    .clk(clk), .resetN(resetN), .startOfFrame(s_zero), .startKey(s_key),
    .SingleHitPulse(s_hit), .deathPulse(s_zero), .scoreBCD(s_score), .lives(s_lives),
    .level(s_level), .gameState(s_state), .freeze(s_freeze), .gameOver(s_go),
    .highScoreBCD(s_high)
  );

  typedef struct {
    logic [1:0]  st;
    logic [15:0] score;
    logic [2:0]  lives;
    logic [2:0]  level;
    logic        fr;
    logic        go;
    logic [15:0] high;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Model state: plain integers, state 0..3 as in gameState.
  int m_state, m_score, m_lives, m_level, m_hits, m_frames, m_high;
  bit m_seen_low;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = 0; m_level = 0;
    m_hits = 0; m_frames = 0; m_high = 0; m_seen_low = 0;
  endtask

  task automatic model_apply(input bit s, input bit k, input bit h, input bit d);
    case (m_state)
      0: if (k) begin
        m_score = 0; m_lives = INIT_LIVES; m_level = 1; m_hits = 0; m_state = 1;
      end
      1: if (d) begin
        m_lives = m_lives - 1;
        m_frames = FF;
        if (m_lives == 0) begin
          m_state = 3; m_seen_low = 0;
          if (m_score > m_high) m_high = m_score;
        end else begin
          m_state = 2;
        end
      end else if (h) begin
        m_score = (m_score + PPH > 9999) ? 9999 : m_score + PPH;
        m_hits++;
        if (m_hits == HPL) begin
          m_hits = 0;
          if (m_level < MAXL) m_level++;
        end
      end
      2: if (m_frames == 0) m_state = 1;
         else if (s) m_frames--;
      default: if (m_seen_low && k) m_state = 0;
               else if (!k) m_seen_low = 1;
    endcase
  endtask

  task automatic step(input bit s, input bit k, input bit h, input bit d);
    exp_t e;
    @(negedge clk);
    sof = s; key = k; hit = h; death = d;
    model_apply(s, k, h, d);
    e.st = 2'(m_state);
    e.score = to_bcd(m_score);
    e.lives = 3'(m_lives);
    e.level = 3'(m_level);
    e.fr = (m_state == 2);
    e.go = (m_state == 3);
`ifdef SCORE_HIGH_SCORE_EN
    e.high = to_bcd(m_high);
`else
    e.high = 16'h0000;
`endif
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 16'(state_o), 16'd0);
    check({tag, "_score"}, score_o, 16'h0000);
    check({tag, "_lives"}, 16'(lives_o), 16'd0);
    check({tag, "_level"}, 16'(level_o), 16'd0);
    check({tag, "_freeze"}, 16'(freeze_o), 16'd0);
    check({tag, "_gameover"}, 16'(go_o), 16'd0);
    check({tag, "_high"}, high_o, 16'h0000);
  endtask

  // Monitor: outputs settle after each posedge; one expectation per clocked step.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state", 16'(state_o), 16'(e.st));
        check("score", score_o, e.score);
        check("lives", 16'(lives_o), 16'(e.lives));
        check("level", 16'(level_o), 16'(e.level));
        check("freeze", 16'(freeze_o), 16'(e.fr));
        check("gameover", 16'(go_o), 16'(e.go));
        check("high", high_o, e.high);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    resetN = 1'b1;

    // Saturation instance: 5 points per hit, 1999 hits reach 9995.
    @(negedge clk); s_key = 1'b1;
    @(negedge clk); s_key = 1'b0;
    for (int i = 0; i < 1999; i++) begin
      @(negedge clk);
      if (i == 200) check("sat_mid_score", s_score, 16'h1000);
      s_hit = 1'b1;
    end
    @(negedge clk); s_hit = 1'b0;
    check("sat_9995", s_score, 16'h9995);
    @(negedge clk); s_hit = 1'b1;
    @(negedge clk); s_hit = 1'b0;
    check("sat_9999", s_score, 16'h9999);
    @(negedge clk); s_hit = 1'b1;
    @(negedge clk); s_hit = 1'b0;
    check("sat_hold", s_score, 16'h9999);
    check("sat_level", 16'(s_level), 16'd7);
    check("sat_lives", 16'(s_lives), 16'd3);

    // Start, then hits in IDLE are ignored until the key is seen.
    step(0, 0, 1, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
    for (int i = 0; i < 35; i++) step(i % 3 == 0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Asynchronous reset mid-game.
    @(negedge clk);
    resetN = 1'b0;
    model_reset();
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    resetN = 1'b1;

    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < FF; i++) begin
      step(1, 0, 1, 0);
      step(0, 0, 1, 0);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    for (int i = 0; i < FF + 2; i++) step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);

    // Random play, games end and restart as the key toggles.
    for (int i = 0; i < 3000; i++) begin
      bit s, h, d, k;
      s = ($urandom % 4) == 0;
      h = ($urandom % 3) == 0;
      d = ($urandom % 25) == 0;
      k = (($urandom % 8) == 0) ? ~key : key;
      step(s, k, h, d);
    end

    step(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
